// File: rtl/dotacc_pkg.sv
// dotacc_pkg: shared types and widths for the dot-product accumulator
package dotacc_pkg;
  typedef enum logic {ST_ACCUM, ST_HOLD} state_e;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
endpackage

// File: rtl/dot_product_accumulator_mult.sv
// Multiplier: combinational unsigned OP_W x OP_W multiply
// Ports: A, B operands in; Res PROD_W-bit product out.
module Multiplier
  import dotacc_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Res
);
  assign Res = PROD_W'(A) * PROD_W'(B);
endmodule

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: accumulates LEN products A*B and presents the sum over valid/ready
// Ports: Clk, Rst_n (async active-low); In_Valid/In_Ready with A, B operand pair in;
// Out_Valid/Out_Ready with Sum and Ovf result out.
// Build option DOTACC_SAT_EN: saturate Acc/Sum at 2^ACC_W-1 instead of wrapping.
module dot_product_accumulator
  import dotacc_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [ACC_W-1:0] Sum,
  output logic             Ovf
);
  localparam int CW = $clog2(LEN);
  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, sum_q, sum_d, step;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     add;
  logic               carry, accept, last;
  Multiplier u_mult (.A(A), .B(B), .Res(prod));
  assign add    = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign carry  = add[ACC_W];
`ifdef DOTACC_SAT_EN
  // Once clamped, any nonzero add carries again, so the clamp persists for the vector.
  assign step   = carry ? {ACC_W{1'b1}} : add[ACC_W-1:0];
`else
  assign step   = add[ACC_W-1:0];
`endif
  assign accept    = In_Valid && state_q == ST_ACCUM;
  assign last      = cnt_q == CW'(LEN-1);
  assign In_Ready  = state_q == ST_ACCUM;
  assign Out_Valid = state_q == ST_HOLD;
  assign Sum       = sum_q;
  assign Ovf       = ovf_q;
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    if (accept && !last) begin
      acc_d     = step;
      cnt_d     = cnt_q + 1'b1;
      ovf_acc_d = ovf_acc_q | carry;
    end
    if (accept && last) begin
      sum_d     = step;
      ovf_d     = ovf_acc_q | carry;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
      state_d   = ST_HOLD;
    end
    if (state_q == ST_HOLD && Out_Ready) state_d = ST_ACCUM;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator: directed and random checks of two accumulators (ACC_W 10 and 8)
module tb_dot_product_accumulator;
  logic Clk = 0, Rst_n = 0, In_Valid = 0, Out_Ready = 1;
  logic [3:0] A = 0, B = 0;
  logic ir0, ov0, f0, ir1, ov1, f1;
  logic [9:0] s0;
  logic [7:0] s1;
  int n = 0, fails = 0, cyc = 0, tot = 0;
  int e0s, e0f, e1s, e1f;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;
  dot_product_accumulator #(.LEN(4), .ACC_W(10)) u0 (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(ir0), .A(A), .B(B),
    .Out_Valid(ov0), .Out_Ready(Out_Ready), .Sum(s0), .Ovf(f0));
  dot_product_accumulator #(.LEN(4), .ACC_W(8)) u1 (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(ir1), .A(A), .B(B),
    .Out_Valid(ov1), .Out_Ready(Out_Ready), .Sum(s1), .Ovf(f1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_sum(int t, int w);
    int m = (1 << w) - 1;
`ifdef DOTACC_SAT_EN
    return t > m ? m : t;
`else
    return t & m;
`endif
  endfunction
  task automatic push(input int a, input int b, output int waits);
    waits = 0;
    In_Valid = 1;
    A = 4'(a);
    B = 4'(b);
    while (!ir0 && waits < 20) begin
      @(negedge Clk);
      waits++;
    end
    if (!ir0) begin
      n++;
      fails++;
      $error("FAIL push_timeout: observed In_Ready %0d expected 1", ir0);
    end
    @(negedge Clk);
    In_Valid = 0;
    tot += a * b;
  endtask
  task automatic check_result(input string tag);
    e0s = exp_sum(tot, 10);
    e0f = tot > 1023 ? 1 : 0;
    e1s = exp_sum(tot, 8);
    e1f = tot > 255 ? 1 : 0;
    chk({tag, "_ov0"}, ov0, 1);
    chk({tag, "_ir0"}, ir0, 0);
    chk({tag, "_sum0"}, s0, e0s);
    chk({tag, "_ovf0"}, f0, e0f);
    chk({tag, "_ov1"}, ov1, 1);
    chk({tag, "_sum1"}, s1, e1s);
    chk({tag, "_ovf1"}, f1, e1f);
    tot = 0;
  endtask
  task automatic hold_release(input string tag, input int k);
    Out_Ready = 0;
    repeat (k) begin
      @(negedge Clk);
      chk({tag, "_hold_ov"}, ov0, 1);
      chk({tag, "_hold_ir"}, ir0, 0);
      chk({tag, "_hold_sum0"}, s0, e0s);
      chk({tag, "_hold_ovf1"}, f1, e1f);
      chk({tag, "_hold_sum1"}, s1, e1s);
    end
    Out_Ready = 1;
    @(negedge Clk);
    chk({tag, "_rel_ov"}, ov0, 0);
    chk({tag, "_rel_ir"}, ir0, 1);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_ir0"}, ir0, 1);
    chk({tag, "_ov0"}, ov0, 0);
    chk({tag, "_sum0"}, s0, 0);
    chk({tag, "_ovf0"}, f0, 0);
    chk({tag, "_ir1"}, ir1, 1);
    chk({tag, "_ov1"}, ov1, 0);
    chk({tag, "_sum1"}, s1, 0);
    chk({tag, "_ovf1"}, f1, 0);
  endtask
  initial begin
    int w, t0, k;
    #1 check_reset("reset");
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    @(negedge Clk);
    check_reset("post_reset");
    push(3, 5, w); t0 = cyc;
    push(15, 15, w); push(0, 9, w); push(2, 2, w);
    chk("basic_latency", cyc - t0, 3);
    check_result("basic");
    hold_release("basic", 0);
    for (int i = 0; i < 4; i++) push(15, 15, w);
    check_result("ovf");
    hold_release("ovf", 1);
    Out_Ready = 0;
    for (int i = 0; i < 4; i++) push(6, 7, w);
    check_result("bp");
    In_Valid = 1; A = 15; B = 15;
    hold_release("bp", 5);
    In_Valid = 0;
    for (int i = 0; i < 4; i++) push(1, 1, w);
    check_result("bp_next");
    chk("bp_next_sum_lit", s0, 4);
    hold_release("bp_next", 0);
    push(4, 4, w); t0 = cyc;
    push(4, 4, w);
    repeat (3) @(negedge Clk);
    push(4, 4, w); push(4, 4, w);
    chk("gap_latency", cyc - t0, 6);
    check_result("gap");
    chk("gap_sum_lit", s0, 64);
    hold_release("gap", 0);
    push(15, 15, w); push(15, 15, w);
    Rst_n = 0;
    #1 check_reset("midrst");
    @(negedge Clk);
    check_reset("midrst_hold");
    Rst_n = 1;
    tot = 0;
    for (int i = 0; i < 4; i++) push(1, 2, w);
    check_result("after_rst");
    chk("after_rst_sum_lit", s0, 8);
    hold_release("after_rst", 0);
    Out_Ready = 1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) begin
        push($urandom_range(0, 15), $urandom_range(0, 15), w);
        chk($sformatf("consec_wait_v%0d_p%0d", v, i), w, (v > 0 && i == 0) ? 1 : 0);
      end
      check_result($sformatf("consec%0d", v));
    end
    @(negedge Clk);
    chk("consec_end_ir", ir0, 1);
    for (int v = 0; v < 8; v++) begin
      Out_Ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        if (i > 0) repeat ($urandom_range(0, 2)) @(negedge Clk);
        push($urandom_range(0, 15), $urandom_range(0, 15), w);
      end
      check_result($sformatf("rnd%0d", v));
      k = $urandom_range(0, 3);
      hold_release($sformatf("rnd%0d", v), k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Sequential stage directly downstream of the team's 4x4 combinational array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and feeds each pair to one `Multiplier` instance. It accumulates the 8-bit products over a vector of `LEN` pairs, then presents the dot-product sum on a valid/ready output. It is the bridge between the combinational datapath and the sequenced filter/dot-product logic above it.

## Interface
- `LEN`, default 4: pairs per vector; legal range 2..255.
- `ACC_W`, default 10: accumulator and `Sum` width; must be ≥ 8.
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Rst_n`  in  1  reset, asynchronous assert, active-low.
- `In_Valid`  in  1  operand pair present.
- `In_Ready`  out  1  block accepts a pair this cycle.
- `A`  in  4  unsigned multiplicand.
- `B`  in  4  unsigned multiplier.
- `Out_Valid`  out  1  `Sum`/`Ovf` hold a completed vector result.
- `Out_Ready`  in  1  consumer takes the result this cycle.
- `Sum`  out  `ACC_W`  dot-product result.
- `Ovf`  out  1  some accumulation step in this vector exceeded `ACC_W` bits.

## Operation
- FSM has two states: ACCUM and HOLD. `In_Ready` is 1 exactly when in ACCUM. `Out_Valid` is 1 exactly when in HOLD.
- Accept condition: `In_Valid && In_Ready`. Product = `A*B` from the `Multiplier` instance, zero-extended to `ACC_W+1` bits.
- On accept with `Count < LEN-1`:
  - `Acc <= Acc + prod`
  - `Count++`
  - `OvfAcc` is set if bit `ACC_W` of the sum is 1.
- On accept with `Count == LEN-1` (last pair):
  - `Sum <= Acc + prod`, with the overflow rule applied.
  - `Ovf <= OvfAcc | carry`.
  - `Acc`, `Count` and `OvfAcc` are cleared; state moves to HOLD.
- In HOLD: `Sum` and `Ovf` are stable. `In_Valid` is ignored (no accept).
- HOLD with `Out_Ready = 1`: state returns to ACCUM on the next edge. `Sum` and `Ovf` keep their last values; they are don't-care while `Out_Valid = 0`.
- `In_Valid` gaps inside a vector are allowed: no accept, no state change.
- Arithmetic is unsigned. The single-step maximum product is 225.
- Reset mid-vector: the partial accumulation is discarded and the vector restarts with the next accepted pair.
- Reset values:
  - state ACCUM, `Acc = 0`, `Count = 0`, `OvfAcc = 0`
  - `Sum = 0`, `Ovf = 0`, `Out_Valid = 0`, `In_Ready = 1`

## Timing
- Throughput is one pair per cycle within a vector.
- `Out_Valid` rises on the edge that accepts the last pair, so it is visible in the following cycle.
- Minimum one-cycle input bubble per vector (the HOLD cycle). A full vector occupies ≥ `LEN+1` cycles.
- `Out_Ready` held low stalls indefinitely in HOLD. The upstream sees `In_Ready = 0` for the whole stall.
- `In_Ready` and `Out_Valid` are decoded from registered state only; there is no combinational path from inputs.
- The multiplier path is combinational from `A`/`B` to the `Acc` adder. The `Multiplier` plus `ACC_W`-bit add must close in one cycle.

## Configuration
- Macro `DOTACC_SAT_EN`:
  - Defined: any overflow clamps `Acc` and `Sum` to `2^ACC_W-1` for the rest of the vector. Further adds keep the clamped value.
  - Undefined: accumulation wraps modulo `2^ACC_W`.
- `Ovf` behaves identically in both builds.

## Structure
- Package `dotacc_pkg`:
  - state enum typedef (`ST_ACCUM`, `ST_HOLD`)
  - `OP_W = 4` and `PROD_W = 8` constants
- One sub-module: a single `Multiplier` instance (`u_mult`). Its 8-bit `Res` output is the product.
- Counter width is `$clog2(LEN)`. Everything else stays in the top module.

## Test plan
- Basic vector (`LEN=4`, `ACC_W=10`): pairs (3,5), (15,15), (0,9), (2,2) back-to-back -> `Out_Valid` one cycle after 4th accept, `Sum = 244`, `Ovf = 0`.
- Overflow (`LEN=4`, `ACC_W=8`): four pairs (15,15) -> `Ovf = 1`; `Sum = 132` without `DOTACC_SAT_EN`, `Sum = 255` with it.
- Backpressure: hold `Out_Ready = 0` for 5 cycles after result -> `Sum` and `Ovf` stable, `In_Ready = 0` throughout, pairs presented meanwhile are not accumulated. Next vector (1,1)×4 gives `Sum = 4`.
- Input gaps: drop `In_Valid` for 3 cycles between pairs 2 and 3 of (4,4)×4 -> `Sum = 64`, result timing shifted by exactly 3 cycles.
- Reset mid-vector: accept (15,15), (15,15), assert `Rst_n = 0` for 1 cycle, then (1,2)×4 -> all outputs at reset values during reset, then `Sum = 8`, `Ovf = 0`.
- Consecutive vectors with `Out_Ready = 1` always -> exactly one bubble cycle (`In_Ready = 0`) between vectors, and no accumulation carried over between vectors.
